// File: rtl/mc_datapath_pkg.sv
// Shared encodings for the multicycle MIPS-subset datapath, its control PLA and the bench.
package mc_datapath_pkg;

    // Internal ALU operation selected from AOP and the funct field
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctrl_t;

    // AOP encodings
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_ADD2  = 2'b11;

    // ALU B source encodings
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source encodings
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_HOLD   = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // Maps the control-word ALU op plus funct field to an ALU operation; unknown funct adds
    function automatic alu_ctrl_t alu_decode(input logic [1:0] aop, input logic [5:0] funct);
        alu_ctrl_t ctrl;
        ctrl = ALU_ADD;
        case (aop)
            AOP_SUB: ctrl = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_SUB:  ctrl = ALU_SUB;
                    FN_AND:  ctrl = ALU_AND;
                    FN_OR:   ctrl = ALU_OR;
                    FN_SLT:  ctrl = ALU_SLT;
                    default: ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// 32-entry register file, two combinational read ports and one clocked write port.
// R0 is hardwired to zero; reads see the pre-edge contents (no write bypass).
module mc_regfile
    import mc_datapath_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [4:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [4:0]    raddr_a,
    input  logic [4:0]    raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] regs [32];

    // Register storage: cleared on reset, written on the clock edge, R0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and
// sign extender, steered each cycle by the control word from the control PLA.
// The jump-target concatenation assumes the nominal 32-bit width.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PCW,
    input  logic          PCWC,
    input  logic          ID,
    input  logic          MR,
    input  logic          MW,
    input  logic          IRW,
    input  logic          M2R,
    input  logic [1:0]    PCS,
    input  logic [1:0]    AOP,
    input  logic          ASRCA,
    input  logic [1:0]    ASRCB,
    input  logic          RW,
    input  logic          RD,
    output logic [5:0]    OP,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          zero
);

    logic [DW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] mdr;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [DW-1:0] alu_out;

    logic [DW-1:0] rf_a;
    logic [DW-1:0] rf_b;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    logic [DW-1:0] sext_imm;
    logic [DW-1:0] jump_target;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    alu_ctrl_t     alu_ctrl;
    logic [DW-1:0] pc_next;
    logic          pc_we;

    assign rf_waddr = RD  ? ir[15:11] : ir[20:16];
    assign rf_wdata = M2R ? mdr : alu_out;

    mc_regfile #(.DW(DW)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (RW),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ir[25:21]),
        .raddr_b (ir[20:16]),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    assign sext_imm    = {{(DW-16){ir[15]}}, ir[15:0]};
    assign jump_target = {pc[DW-1:DW-4], ir[25:0], 2'b00};
    assign alu_a       = ASRCA ? a_reg : pc;
    assign alu_ctrl    = alu_decode(AOP, ir[5:0]);

    // ALU B operand select
    always_comb begin
        alu_b = b_reg;
        case (ASRCB)
            SRCB_B:       alu_b = b_reg;
            SRCB_FOUR:    alu_b = DW'(4);
            SRCB_IMM:     alu_b = sext_imm;
            SRCB_IMM_SH2: alu_b = {sext_imm[DW-3:0], 2'b00};
            default:      alu_b = b_reg;
        endcase
    end

    // ALU: wrap-around arithmetic, signed set-less-than yields 0 or 1
    always_comb begin
        alu_result = alu_a + alu_b;
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_SLT: alu_result = {{(DW-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = alu_a + alu_b;
        endcase
    end

    assign zero = (alu_result == '0);

    // Next-PC source select; hold keeps the current PC even when a write is requested
    always_comb begin
        pc_next = pc;
        case (PCS)
            PCS_ALU:    pc_next = alu_result;
            PCS_ALUOUT: pc_next = alu_out;
            PCS_JUMP:   pc_next = jump_target;
            PCS_HOLD:   pc_next = pc;
            default:    pc_next = pc;
        endcase
    end

    assign pc_we = PCW | (PCWC & zero);

    // Architectural state: MDR/A/B/ALUOut load every cycle, IR and PC only when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            mdr     <= mem_rdata;
            a_reg   <= rf_a;
            b_reg   <= rf_b;
            alu_out <= alu_result;
            if (IRW) begin
                ir <= mem_rdata;
            end
            if (pc_we) begin
                pc <= pc_next;
            end
        end
    end

    assign OP        = ir[31:26];
    assign mem_addr  = ID ? alu_out : pc;
    assign mem_wdata = b_reg;
    assign mem_rd    = MR;
    assign mem_wr    = MW;

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: stimulus drives a control word each cycle and queues
// hand-computed expectations; a monitor pops and compares them on the falling edge.
module tb_mc_datapath;
    import mc_datapath_pkg::*;

    localparam int SEL_OP    = 0;
    localparam int SEL_ADDR  = 1;
    localparam int SEL_WDATA = 2;
    localparam int SEL_ZERO  = 3;
    localparam int SEL_RD    = 4;
    localparam int SEL_WR    = 5;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       id;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic [1:0] pcs;
        logic [1:0] aop;
        logic       asrca;
        logic [1:0] asrcb;
        logic       rw;
        logic       rd;
    } ctrl_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCW = 1'b0, PCWC = 1'b0, ID = 1'b0, MR = 1'b0, MW = 1'b0, IRW = 1'b0;
    logic        M2R = 1'b0, ASRCA = 1'b0, RW = 1'b0, RD = 1'b0;
    logic [1:0]  PCS = 2'b11, AOP = 2'b00, ASRCB = 2'b00;
    logic [5:0]  OP;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rd, mem_wr, zero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mc_datapath #(.DW(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PCW       (PCW),
        .PCWC      (PCWC),
        .ID        (ID),
        .MR        (MR),
        .MW        (MW),
        .IRW       (IRW),
        .M2R       (M2R),
        .PCS       (PCS),
        .AOP       (AOP),
        .ASRCA     (ASRCA),
        .ASRCB     (ASRCB),
        .RW        (RW),
        .RD        (RD),
        .OP        (OP),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .zero      (zero)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic ctrl_t idle();
        ctrl_t c;
        c = '0;
        c.pcs = PCS_HOLD;
        return c;
    endfunction

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            SEL_OP:    return {26'b0, OP};
            SEL_ADDR:  return mem_addr;
            SEL_WDATA: return mem_wdata;
            SEL_ZERO:  return {31'b0, zero};
            SEL_RD:    return {31'b0, mem_rd};
            SEL_WR:    return {31'b0, mem_wr};
            default:   return 32'h0;
        endcase
    endfunction

    // Drives one control word just after the rising edge; it takes effect at the next edge
    task automatic applyStimulus(input ctrl_t c, input logic [31:0] rdata);
        @(posedge clk);
        #2;
        PCW = c.pcw;   PCWC = c.pcwc; ID = c.id;   MR = c.mr;  MW = c.mw;
        IRW = c.irw;   M2R = c.m2r;   PCS = c.pcs; AOP = c.aop;
        ASRCA = c.asrca; ASRCB = c.asrcb; RW = c.rw; RD = c.rd;
        mem_rdata = rdata;
    endtask

    // Queues an expectation for the outputs of the current cycle
    task automatic checkOutput(input string name, input int sel, input logic [31:0] value);
        exp_t e;
        e.name = name;
        e.sel = sel;
        e.value = value;
        sb.push_back(e);
    endtask

    // Loads R[idx] through IR.rt and the MDR path
    task automatic setReg(input logic [4:0] idx, input logic [31:0] val);
        ctrl_t c;
        c = idle(); c.irw = 1'b1;
        applyStimulus(c, {6'h23, 5'd0, idx, 16'h0});
        c = idle();
        applyStimulus(c, val);
        c = idle(); c.rw = 1'b1; c.m2r = 1'b1;
        applyStimulus(c, 32'h0);
    endtask

    // Observes R[idx] on mem_wdata via the B register
    task automatic readReg(input string name, input logic [4:0] idx, input logic [31:0] exp);
        ctrl_t c;
        c = idle(); c.irw = 1'b1;
        applyStimulus(c, {6'h2B, 5'd0, idx, 16'h0});
        c = idle();
        applyStimulus(c, 32'h0);
        applyStimulus(c, 32'h0);
        checkOutput(name, SEL_WDATA, exp);
    endtask

    // Executes funct on R1,R2 into R3 and checks ALUOut through mem_addr
    task automatic rtype(input string name, input logic [5:0] funct, input logic [31:0] exp);
        ctrl_t c;
        c = idle(); c.irw = 1'b1;
        applyStimulus(c, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, funct});
        c = idle();
        applyStimulus(c, 32'h0);
        c = idle(); c.asrca = 1'b1; c.asrcb = SRCB_B; c.aop = AOP_FUNCT;
        applyStimulus(c, 32'h0);
        checkOutput({name, "_zero"}, SEL_ZERO, {31'b0, (exp == 32'h0)});
        c = idle(); c.rw = 1'b1; c.rd = 1'b1; c.id = 1'b1;
        applyStimulus(c, 32'h0);
        checkOutput(name, SEL_ADDR, exp);
    endtask

    task automatic fetch(input logic [31:0] instr);
        ctrl_t c;
        c = idle(); c.irw = 1'b1; c.pcw = 1'b1; c.mr = 1'b1;
        c.pcs = PCS_ALU; c.asrcb = SRCB_FOUR; c.aop = AOP_ADD;
        applyStimulus(c, instr);
    endtask

    // Monitor: compares every queued expectation against the settled outputs
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] actual;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            actual = sample(e.sel);
            checks++;
            if (actual !== e.value) begin
                errors++;
                $display("[TB] FAIL %s actual=%h required=%h", e.name, actual, e.value);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        ctrl_t c;

        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("reset_pc", SEL_ADDR, 32'h0);
        checkOutput("reset_op", SEL_OP, 32'h0);
        checkOutput("reset_b", SEL_WDATA, 32'h0);
        checkOutput("reset_zero", SEL_ZERO, 32'h1);
        applyStimulus(c, 32'h0);
        rst_n = 1'b1;

        fetch(32'h8C220004);
        checkOutput("fetch_addr", SEL_ADDR, 32'h0);
        checkOutput("fetch_memrd", SEL_RD, 32'h1);
        checkOutput("fetch_zero", SEL_ZERO, 32'h0);
        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("fetch_op", SEL_OP, {26'b0, OP_LW});
        checkOutput("fetch_pc4", SEL_ADDR, 32'h4);

        setReg(5'd1, 32'd5);
        setReg(5'd2, 32'd7);
        rtype("add", FN_ADD, 32'd12);
        readReg("add_r3", 5'd3, 32'd12);
        rtype("sub", FN_SUB, 32'hFFFF_FFFE);
        setReg(5'd1, 32'hFFFF_FFFF);
        rtype("slt", FN_SLT, 32'd1);
        readReg("slt_r3", 5'd3, 32'd1);
        rtype("and", FN_AND, 32'd7);
        rtype("or", FN_OR, 32'hFFFF_FFFF);
        rtype("sub_neg", FN_SUB, 32'hFFFF_FFF8);

        setReg(5'd1, 32'h100);
        c = idle(); c.irw = 1'b1;
        applyStimulus(c, 32'h8C220004);
        c = idle();
        applyStimulus(c, 32'h0);
        c = idle(); c.asrca = 1'b1; c.asrcb = SRCB_IMM; c.aop = AOP_ADD;
        applyStimulus(c, 32'h0);
        c = idle(); c.id = 1'b1; c.mr = 1'b1;
        applyStimulus(c, 32'hDEAD_BEEF);
        checkOutput("lw_addr", SEL_ADDR, 32'h104);
        checkOutput("lw_memrd", SEL_RD, 32'h1);
        checkOutput("lw_memwr", SEL_WR, 32'h0);
        c = idle(); c.rw = 1'b1; c.m2r = 1'b1;
        applyStimulus(c, 32'h0);
        readReg("lw_r2", 5'd2, 32'hDEAD_BEEF);
        c = idle(); c.mw = 1'b1; c.id = 1'b1;
        applyStimulus(c, 32'h0);
        checkOutput("sw_memwr", SEL_WR, 32'h1);
        checkOutput("sw_wdata", SEL_WDATA, 32'hDEAD_BEEF);

        setReg(5'd1, 32'd9);
        setReg(5'd2, 32'd8);
        fetch(32'h1022_0003);
        checkOutput("beq_fetch_addr", SEL_ADDR, 32'h4);
        c = idle(); c.asrcb = SRCB_IMM_SH2; c.aop = AOP_ADD;
        applyStimulus(c, 32'h0);
        checkOutput("beq_op", SEL_OP, {26'b0, OP_BEQ});
        checkOutput("beq_pc8", SEL_ADDR, 32'h8);
        c = idle(); c.asrca = 1'b1; c.aop = AOP_SUB; c.pcwc = 1'b1; c.pcs = PCS_ALUOUT;
        applyStimulus(c, 32'h0);
        checkOutput("bne_zero", SEL_ZERO, 32'h0);
        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("bne_pc", SEL_ADDR, 32'h8);

        setReg(5'd2, 32'd9);
        c = idle(); c.irw = 1'b1;
        applyStimulus(c, 32'h1022_0003);
        c = idle(); c.asrcb = SRCB_IMM_SH2; c.aop = AOP_ADD;
        applyStimulus(c, 32'h0);
        c = idle(); c.asrca = 1'b1; c.aop = AOP_SUB; c.pcwc = 1'b1; c.pcs = PCS_ALUOUT;
        applyStimulus(c, 32'h0);
        checkOutput("beq_zero", SEL_ZERO, 32'h1);
        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("beq_pc", SEL_ADDR, 32'd20);

        c = idle(); c.irw = 1'b1;
        applyStimulus(c, 32'h0800_0010);
        c = idle(); c.pcw = 1'b1; c.pcs = PCS_JUMP;
        applyStimulus(c, 32'h0);
        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("jump_pc", SEL_ADDR, 32'h40);
        c = idle(); c.pcw = 1'b1; c.pcs = PCS_HOLD;
        applyStimulus(c, 32'h0);
        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("hold_pc", SEL_ADDR, 32'h40);

        setReg(5'd0, 32'h55);
        readReg("r0_zero", 5'd0, 32'h0);

        setReg(5'd5, 32'h11);
        c = idle();
        applyStimulus(c, 32'h22);
        c = idle(); c.rw = 1'b1; c.m2r = 1'b1;
        applyStimulus(c, 32'h0);
        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("wr_rd_old", SEL_WDATA, 32'h11);
        applyStimulus(c, 32'h0);
        checkOutput("wr_rd_new", SEL_WDATA, 32'h22);

        c = idle();
        applyStimulus(c, 32'h0);
        rst_n = 1'b0;
        checkOutput("async_rst_pc", SEL_ADDR, 32'h0);
        checkOutput("async_rst_op", SEL_OP, 32'h0);
        checkOutput("async_rst_b", SEL_WDATA, 32'h0);
        applyStimulus(c, 32'h0);
        rst_n = 1'b1;
        fetch(32'h8C220004);
        checkOutput("refetch_addr", SEL_ADDR, 32'h0);
        c = idle();
        applyStimulus(c, 32'h0);
        checkOutput("refetch_op", SEL_OP, {26'b0, OP_LW});
        checkOutput("refetch_pc4", SEL_ADDR, 32'h4);
        readReg("rst_r5", 5'd5, 32'h0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
